// File: rtl/xrv1_wb_arb.sv
// xrv1_wb_arb -- write-back arbiter and register busy scoreboard.
//
// The only producer of the integer register file write port. Results from
// N_SRC_P execution sources arrive over valid/ready handshakes. A
// combinational round-robin arbiter accepts at most one result per cycle.
// That result is registered onto the RF write port. A per-register busy
// scoreboard tracks destinations that are still in flight, so issue logic
// can stall on RAW and WAW hazards.
//
// Ports:
//   clk_i, rst_i             clock; asynchronous active-high reset
//   issue_v_i, issue_rd_i    instruction issuing with a register destination
//   issue_rdy_o              issue permitted (destination not busy, or x0)
//   rs0_addr_i, rs1_addr_i   sources of the instruction in decode
//   hazard_o                 a nonzero source register is busy
//   src_v_i/src_rd_i/src_data_i  per-source result handshake (packed by source)
//   src_rdy_o                per-source accept (one-hot or zero)
//   rd_w_en_o/rd_addr_o/rd_data_o  registered RF write port
//   busy_o                   scoreboard vector (bit 0 always 0)
module xrv1_wb_arb #(
    parameter int unsigned DATA_WIDTH_P    = 32,
    parameter int unsigned rf_addr_width_p = 5,
    parameter int unsigned rf_size_lp      = 1 << rf_addr_width_p,
    parameter int unsigned N_SRC_P         = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 issue_v_i,
    input  logic [rf_addr_width_p-1:0]           issue_rd_i,
    output logic                                 issue_rdy_o,
    input  logic [rf_addr_width_p-1:0]           rs0_addr_i,
    input  logic [rf_addr_width_p-1:0]           rs1_addr_i,
    output logic                                 hazard_o,
    input  logic [N_SRC_P-1:0]                   src_v_i,
    input  logic [N_SRC_P*rf_addr_width_p-1:0]   src_rd_i,
    input  logic [N_SRC_P*DATA_WIDTH_P-1:0]      src_data_i,
    output logic [N_SRC_P-1:0]                   src_rdy_o,
    output logic                                 rd_w_en_o,
    output logic [rf_addr_width_p-1:0]           rd_addr_o,
    output logic [DATA_WIDTH_P-1:0]              rd_data_o,
    output logic [rf_size_lp-1:0]                busy_o
);

    localparam int unsigned AW = rf_addr_width_p;
    localparam int unsigned DW = DATA_WIDTH_P;
    localparam int unsigned PW = (N_SRC_P > 1) ? $clog2(N_SRC_P) : 1;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic [AW-1:0]         gnt_rd;
    logic [DW-1:0]         gnt_data;

    logic                  wen_q, wen_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;

    logic [rf_size_lp-1:0] busy_q, busy_d;
    logic [rf_size_lp-1:0] set_vec, clr_vec;

    // Round-robin search: the first valid source at or after the pointer.
    always_comb begin
        int unsigned cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_SRC_P; i++) begin
            cand = (32'(ptr_q) + i) % N_SRC_P;
            if (!gnt_any && src_v_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        src_rdy_o = '0;
        if (gnt_any) begin
            src_rdy_o[gnt_idx] = 1'b1;
        end
        gnt_rd   = src_rd_i[gnt_idx*AW +: AW];
        gnt_data = src_data_i[gnt_idx*DW +: DW];
    end

    // The pointer advances past the granted source and holds when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(N_SRC_P - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Write stage. The address/data capture every accepted result, including
    // results for x0, whose write enable is suppressed.
    always_comb begin
        wen_d  = gnt_any && (gnt_rd != '0);
        addr_d = addr_q;
        data_d = data_q;
        if (gnt_any) begin
            addr_d = gnt_rd;
            data_d = gnt_data;
        end
    end

    // Scoreboard. Writing back busy_q & ~clr | set makes a same-cycle set win.
    always_comb begin
        issue_rdy_o = !busy_q[issue_rd_i] || (issue_rd_i == '0);
        hazard_o    = ((rs0_addr_i != '0) && busy_q[rs0_addr_i]) ||
                      ((rs1_addr_i != '0) && busy_q[rs1_addr_i]);
        set_vec = '0;
        clr_vec = '0;
        if (issue_v_i && issue_rdy_o && (issue_rd_i != '0)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        if (wen_q) begin
            clr_vec[addr_q] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign rd_w_en_o = wen_q;
    assign rd_addr_o = addr_q;
    assign rd_data_o = data_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_xrv1_wb_arb.sv
// Testbench for xrv1_wb_arb: per-cycle vector table plus directed sequences
// for asynchronous reset, sustained contention and idle pointer hold.
module tb_xrv1_wb_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_v;
    logic [4:0]  issue_rd;
    logic        issue_rdy;
    logic [4:0]  rs0, rs1;
    logic        hazard;
    logic [2:0]  src_v;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [2:0]  src_rdy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    xrv1_wb_arb #(
        .DATA_WIDTH_P    (32),
        .rf_addr_width_p (5),
        .N_SRC_P         (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .issue_v_i   (issue_v),
        .issue_rd_i  (issue_rd),
        .issue_rdy_o (issue_rdy),
        .rs0_addr_i  (rs0),
        .rs1_addr_i  (rs1),
        .hazard_o    (hazard),
        .src_v_i     (src_v),
        .src_rd_i    (src_rd),
        .src_data_i  (src_data),
        .src_rdy_o   (src_rdy),
        .rd_w_en_o   (wen),
        .rd_addr_o   (waddr),
        .rd_data_o   (wdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [2:0]  sv;
        logic [14:0] srd;
        logic [95:0] sdat;
        logic [2:0]  e_rdy;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_irdy;
        logic        e_haz;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic iv, logic [4:0] ird, logic [4:0] r0, logic [4:0] r1,
                                logic [2:0] sv, logic [14:0] srd, logic [95:0] sdat,
                                logic [2:0] e_rdy, logic e_wen, logic [4:0] e_addr,
                                logic [31:0] e_data, logic e_irdy, logic e_haz,
                                logic [31:0] e_busy);
        vec_t v;
        v.iv = iv; v.ird = ird; v.r0 = r0; v.r1 = r1;
        v.sv = sv; v.srd = srd; v.sdat = sdat;
        v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
        v.e_irdy = e_irdy; v.e_haz = e_haz; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        issue_v = 1'b0; issue_rd = '0; rs0 = '0; rs1 = '0;
        src_v = '0; src_rd = '0; src_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row-by-row: inputs, then expected outputs for that cycle.
        tbl[0]  = mk(0,0,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd0,32'h0,       1,0,32'h0);
        tbl[1]  = mk(1,5,5,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd0,32'h0,       1,0,32'h0);
        tbl[2]  = mk(0,0,5,0, 3'b010, {5'd0,5'd5,5'd0}, {32'd0,32'hDEADBEEF,32'd0},
                                                    3'b010,0,5'd0,32'h0,       1,1,32'h20);
        tbl[3]  = mk(0,0,5,0, 3'b000, 15'd0, 96'd0, 3'b000,1,5'd5,32'hDEADBEEF,1,1,32'h20);
        tbl[4]  = mk(0,0,5,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd5,32'hDEADBEEF,1,0,32'h0);
        tbl[5]  = mk(1,0,0,0, 3'b001, {10'd0,5'd0}, {64'd0,32'h1234},
                                                    3'b001,0,5'd5,32'hDEADBEEF,1,0,32'h0);
        tbl[6]  = mk(0,0,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd0,32'h1234,    1,0,32'h0);
        tbl[7]  = mk(1,7,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd0,32'h1234,    1,0,32'h0);
        tbl[8]  = mk(1,7,0,0, 3'b100, {5'd7,10'd0}, {32'hA5A50007,64'd0},
                                                    3'b100,0,5'd0,32'h1234,    0,0,32'h80);
        tbl[9]  = mk(1,7,0,0, 3'b000, 15'd0, 96'd0, 3'b000,1,5'd7,32'hA5A50007,0,0,32'h80);
        tbl[10] = mk(1,7,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd7,32'hA5A50007,1,0,32'h0);
        tbl[11] = mk(0,7,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd7,32'hA5A50007,0,0,32'h80);
        tbl[12] = mk(0,0,0,0, 3'b001, {10'd0,5'd9}, {64'd0,32'h99},
                                                    3'b001,0,5'd7,32'hA5A50007,1,0,32'h80);
        tbl[13] = mk(1,9,0,0, 3'b000, 15'd0, 96'd0, 3'b000,1,5'd9,32'h99,      1,0,32'h80);
        tbl[14] = mk(0,0,9,7, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd9,32'h99,      1,1,32'h280);
        tbl[15] = mk(0,0,0,0, 3'b000, 15'd0, 96'd0, 3'b000,0,5'd9,32'h99,      1,0,32'h280);

        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset_wen",  64'(wen),   64'(0));
        chk("reset_addr", 64'(waddr), 64'(0));
        chk("reset_data", 64'(wdata), 64'(0));
        chk("reset_busy", 64'(busy),  64'(0));
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            issue_v = tbl[i].iv; issue_rd = tbl[i].ird;
            rs0 = tbl[i].r0; rs1 = tbl[i].r1;
            src_v = tbl[i].sv; src_rd = tbl[i].srd; src_data = tbl[i].sdat;
            #2;
            chk($sformatf("v%0d_src_rdy", i),   64'(src_rdy),   64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_wen", i),       64'(wen),       64'(tbl[i].e_wen));
            chk($sformatf("v%0d_addr", i),      64'(waddr),     64'(tbl[i].e_addr));
            chk($sformatf("v%0d_data", i),      64'(wdata),     64'(tbl[i].e_data));
            chk($sformatf("v%0d_issue_rdy", i), 64'(issue_rdy), 64'(tbl[i].e_irdy));
            chk($sformatf("v%0d_hazard", i),    64'(hazard),    64'(tbl[i].e_haz));
            chk($sformatf("v%0d_busy", i),      64'(busy),      64'(tbl[i].e_busy));
        end

        // Asynchronous reset mid-cycle while src0 is offering a result.
        @(negedge clk);
        idle_inputs();
        src_v = 3'b001; src_rd = {10'd0, 5'd4}; src_data = {64'd0, 32'h44};
        #2;
        chk("arst_pre_rdy", 64'(src_rdy), 64'(3'b001));
        #1 rst = 1'b1;
        #1;
        chk("arst_wen",  64'(wen),   64'(0));
        chk("arst_addr", 64'(waddr), 64'(0));
        chk("arst_data", 64'(wdata), 64'(0));
        chk("arst_busy", 64'(busy),  64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #2;
        chk("arst_post_wen0", 64'(wen), 64'(0));
        @(negedge clk);
        #2;
        chk("arst_post_wen1", 64'(wen), 64'(0));

        // Contention from pointer 0: grants rotate 0,1,2,0.
        @(negedge clk);
        src_v = 3'b111;
        src_rd = {5'd3, 5'd2, 5'd1};
        src_data = {32'h33, 32'h22, 32'h11};
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("cont%0d_rdy", c), 64'(src_rdy), 64'(3'b001 << (c % 3)));
            if (c == 0) begin
                chk("cont0_wen", 64'(wen), 64'(0));
            end else begin
                chk($sformatf("cont%0d_wen", c),  64'(wen),   64'(1));
                chk($sformatf("cont%0d_addr", c), 64'(waddr), 64'(((c - 1) % 3) + 1));
                chk($sformatf("cont%0d_data", c), 64'(wdata), 64'(32'h11 * (((c - 1) % 3) + 1)));
            end
            @(negedge clk);
        end

        // Idle for 10 cycles; pointer holds at 1 after the last grant to 0.
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            #2;
            chk($sformatf("idle%0d_rdy", k), 64'(src_rdy), 64'(0));
            chk($sformatf("idle%0d_wen", k), 64'(wen), 64'(k == 0 ? 1 : 0));
            @(negedge clk);
        end
        src_v = 3'b101;
        src_rd = {5'd6, 5'd0, 5'd8};
        src_data = {32'h66, 32'h0, 32'h88};
        #2;
        chk("idle_resume_rdy", 64'(src_rdy), 64'(3'b100));
        @(negedge clk);
        idle_inputs();
        #2;
        chk("idle_resume_wen",  64'(wen),   64'(1));
        chk("idle_resume_addr", 64'(waddr), 64'(6));
        chk("idle_resume_data", 64'(wdata), 64'(32'h66));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xrv1_wb_arb.md
Name: xrv1_wb_arb

Overview:
- Write-side companion of the integer register file: the single producer of the RF write port.
- Collects results from N execution sources (ALU, MUL/DIV, LSU, ...) over valid/ready handshakes and arbitrates them round-robin onto one registered write port.
- Keeps a per-register busy scoreboard so issue logic can detect RAW/WAW hazards on in-flight destinations.

Parameters:
- DATA_WIDTH_P, 32, register/result width
- rf_addr_width_p, 5, register address width
- rf_size_lp, 1 << rf_addr_width_p, number of architectural registers (derived)
- N_SRC_P, 3, number of result sources (2..8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- issue_v_i  in  1  instruction issuing this cycle with a register destination
- issue_rd_i  in  rf_addr_width_p  destination of the issuing instruction
- issue_rdy_o  out  1  issue permitted; low when issue_rd_i is busy (WAW stall)
- rs0_addr_i  in  rf_addr_width_p  source 0 of the instruction in decode
- rs1_addr_i  in  rf_addr_width_p  source 1 of the instruction in decode
- hazard_o  out  1  a nonzero rs0/rs1 is busy (RAW stall)
- src_v_i  in  N_SRC_P  per-source result valid
- src_rd_i  in  N_SRC_P*rf_addr_width_p  per-source destination, packed (source k at [k*AW +: AW])
- src_data_i  in  N_SRC_P*DATA_WIDTH_P  per-source result, packed
- src_rdy_o  out  N_SRC_P  per-source accept (one-hot or zero)
- rd_w_en_o  out  1  RF write enable
- rd_addr_o  out  rf_addr_width_p  RF write address
- rd_data_o  out  DATA_WIDTH_P  RF write data
- busy_o  out  rf_size_lp  scoreboard vector (bit 0 always 0)

Behaviour:
- Reset (async, rst_i=1): busy all 0, rd_w_en_o=0, rd_addr_o=0, rd_data_o=0, round-robin pointer=0. Reset mid-transfer drops the in-flight result; no partial write.
- Arbitration: combinational round-robin over src_v_i, starting at the pointer. At most one src_rdy_o bit is high, and only for a valid source. Handshake completes when src_v_i[k] & src_rdy_o[k]. The pointer moves to k+1 (mod N_SRC_P) after a grant and holds when nothing is granted.
- No backpressure from the RF: a grant occurs in every cycle with at least one valid source.
- Sources hold v/rd/data stable until accepted; src_rdy_o never depends on src_rdy_o of another cycle.
- Write stage: registered. The granted rd/data appear on rd_addr_o/rd_data_o with rd_w_en_o=1 exactly 1 cycle after the handshake. Latency handshake->RF write = 1 clk; throughput 1 write per cycle.
- rd_w_en_o=0 in cycles with no grant the previous cycle. rd_addr_o/rd_data_o then hold their last values.
- Writes to x0: handshake accepted normally, but rd_w_en_o is suppressed (0) for that slot.
- Scoreboard:
  - Set busy[issue_rd_i] on issue_v_i & issue_rdy_o, when issue_rd_i != 0.
  - Clear busy[rd_addr_o] in the cycle rd_w_en_o=1. It reads as 0 from the next cycle, which is the same cycle the RF holds the new value.
  - Same-cycle set and clear of the same register: set wins.
- issue_rdy_o = !(busy[issue_rd_i]) | (issue_rd_i==0). Combinational; independent of issue_v_i.
- hazard_o = (rs0_addr_i!=0 & busy[rs0_addr_i]) | (rs1_addr_i!=0 & busy[rs1_addr_i]). Combinational, no bypass.
- A result for a non-busy register is a protocol error. It is still written, and busy is unaffected.
- busy_o[0] tied 0.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with src0 valid -> all outputs 0 immediately; no rd_w_en_o pulse after release.
- Single source: issue x5 (busy_o[5]=1, hazard_o=1 for rs0=5); src1 sends rd=5, data=0xDEADBEEF -> src_rdy_o=3'b010 same cycle; next cycle rd_w_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; following cycle busy_o[5]=0, hazard_o=0.
- Contention: all 3 sources valid continuously (rd=1,2,3) from pointer 0 -> grants 0,1,2,0 on consecutive cycles; rd_w_en_o high every cycle from cycle 1.
- x0 handling: source sends rd=0, data=0x1234 -> handshake completes, rd_w_en_o stays 0; issue_rd_i=0 -> issue_rdy_o=1, busy_o unchanged.
- WAW and set-wins: x7 busy, issue_rd_i=7 -> issue_rdy_o=0. In the cycle rd_w_en_o=1 for x7, issue x7 again (issue_rdy_o=1 only after the clear) -> busy_o[7] stays 1.
- Idle: no valid sources for 10 cycles -> src_rdy_o=0, rd_w_en_o=0, pointer unchanged (next grant goes to the lowest valid index at or after the held pointer).
